// File: rtl/mips_cpu_alu.sv
// Integer ALU for the multicycle MIPS CPU.
// Combinational result/zero for logic, add/sub, compare and shift operations;
// owns the architectural HI/LO registers written by MULT(U), DIV(U), MTHI/MTLO.
// Multiply and divide complete in a single cycle (no busy/stall signalling).
module mips_cpu_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  control,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  sa,
   output logic [31:0] r,
   output logic        zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_XOR   = 4'b0010,
      OP_ADDU  = 4'b0011,
      OP_SUBU  = 4'b0100,
      OP_SLT   = 4'b0101,
      OP_SLTU  = 4'b0110,
      OP_SLL   = 4'b0111,
      OP_SRL   = 4'b1000,
      OP_SRA   = 4'b1001,
      OP_MULT  = 4'b1010,
      OP_MULTU = 4'b1011,
      OP_DIV   = 4'b1100,
      OP_DIVU  = 4'b1101,
      OP_MTHL  = 4'b1110,
      OP_NOP   = 4'b1111
   } aluOp_t;

   aluOp_t op;
   assign op = aluOp_t'(control);

   // 64-bit products: sign-extending both operands to 64 bits makes the
   // truncated unsigned product equal to the two's-complement signed product.
   logic [63:0] prodSigned;
   logic [63:0] prodUnsigned;
   assign prodSigned   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prodUnsigned = {32'h0, a} * {32'h0, b};

   // Signed division is done on magnitudes, then signs are restored. This
   // avoids the overflow corner of -2^31 / -1 (quotient wraps to 0x80000000,
   // remainder 0) and gives truncation toward zero with the remainder
   // carrying the sign of the dividend.
   logic        divByZero;
   logic [31:0] absA;
   logic [31:0] absB;
   logic [31:0] magQuot;
   logic [31:0] magRem;
   logic [31:0] divsQuot;
   logic [31:0] divsRem;
   logic [31:0] divuQuot;
   logic [31:0] divuRem;

   assign divByZero = (b == 32'h0);
   assign absA      = a[31] ? (~a + 32'd1) : a;
   assign absB      = b[31] ? (~b + 32'd1) : b;
   assign magQuot   = divByZero ? 32'h0 : (absA / absB);
   assign magRem    = divByZero ? 32'h0 : (absA % absB);
   assign divsQuot  = (a[31] ^ b[31]) ? (~magQuot + 32'd1) : magQuot;
   assign divsRem   = a[31] ? (~magRem + 32'd1) : magRem;
   assign divuQuot  = divByZero ? 32'h0 : (a / b);
   assign divuRem   = divByZero ? 32'h0 : (a % b);

   // Combinational result; HI/LO-writing codes and NOP produce zero.
   always_comb begin
      r = 32'h0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_ADDU: r = a + b;
         OP_SUBU: r = a - b;
         OP_SLT:  r = {31'h0, ($signed(a) < $signed(b))};
         OP_SLTU: r = {31'h0, (a < b)};
         OP_SLL:  r = b << sa;
         OP_SRL:  r = b >> sa;
         OP_SRA:  r = $unsigned($signed(b) >>> sa);
         default: r = 32'h0;
      endcase
   end

   assign zero = (r == 32'h0);

   // HI/LO register update; reset wins over any write code, divide by zero
   // leaves both registers untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end else begin
         case (op)
            OP_MULT: begin
               hi <= prodSigned[63:32];
               lo <= prodSigned[31:0];
            end
            OP_MULTU: begin
               hi <= prodUnsigned[63:32];
               lo <= prodUnsigned[31:0];
            end
            OP_DIV: begin
               if (!divByZero) begin
                  hi <= divsRem;
                  lo <= divsQuot;
               end
            end
            OP_DIVU: begin
               if (!divByZero) begin
                  hi <= divuRem;
                  lo <= divuQuot;
               end
            end
            OP_MTHL: begin
               if (sa[0]) hi <= a;
               else       lo <= a;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Self-checking bench for mips_cpu_alu: directed literal cases followed by
// randomized operations compared every cycle against a behavioural model.
module tb_mips_cpu_alu;

   logic        clk;
   logic        reset;
   logic [3:0]  control;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  sa;
   logic [31:0] r;
   logic        zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   // Model state: architectural HI/LO as the ALU should hold them.
   logic [31:0] mHi;
   logic [31:0] mLo;
   logic        mValid;

   mips_cpu_alu dut (
      .clk     (clk),
      .reset   (reset),
      .control (control),
      .a       (a),
      .b       (b),
      .sa      (sa),
      .r       (r),
      .zero    (zero),
      .hi      (hi),
      .lo      (lo)
   );

   // Clock and initial input state.
   initial begin
      clk     = 1'b0;
      reset   = 1'b0;
      control = 4'hF;
      a       = 32'h0;
      b       = 32'h0;
      sa      = 5'h0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected combinational result straight from the operation table.
   function automatic logic [31:0] modelR(input logic [3:0] c, input logic [31:0] av,
                                          input logic [31:0] bv, input logic [4:0] s);
      int sbv;
      sbv = int'(bv);
      case (c)
         4'd0:    return av & bv;
         4'd1:    return av | bv;
         4'd2:    return av ^ bv;
         4'd3:    return 32'(longint'(av) + longint'(bv));
         4'd4:    return 32'(longint'(av) - longint'(bv));
         4'd5:    return (int'(av) < int'(bv)) ? 32'd1 : 32'd0;
         4'd6:    return (longint'(av) < longint'(bv)) ? 32'd1 : 32'd0;
         4'd7:    return 32'(longint'(bv) * (longint'(1) << s));
         4'd8:    return 32'(longint'(bv) / (longint'(1) << s));
         4'd9:    return 32'(sbv >>> s);
         default: return 32'h0;
      endcase
   endfunction

   // Expected {hi,lo} after one clock edge with the given inputs.
   function automatic logic [63:0] modelHiLo(input logic rst, input logic [3:0] c,
                                             input logic [31:0] av, input logic [31:0] bv,
                                             input logic [4:0] s, input logic [31:0] h,
                                             input logic [31:0] l);
      longint sA;
      longint sB;
      longint q;
      longint rm;
      sA = longint'(int'(av));
      sB = longint'(int'(bv));
      if (!rst) return 64'h0;
      case (c)
         4'd10: return 64'(sA * sB);
         4'd11: return 64'(longint'(av) * longint'(bv));
         4'd12: begin
            if (bv == 32'h0) return {h, l};
            q  = sA / sB;
            rm = sA % sB;
            return {rm[31:0], q[31:0]};
         end
         4'd13: begin
            if (bv == 32'h0) return {h, l};
            return {av % bv, av / bv};
         end
         4'd14:   return s[0] ? {av, l} : {h, av};
         default: return {h, l};
      endcase
   endfunction

   // Model register update on the same edge the DUT updates.
   always @(posedge clk) begin
      {mHi, mLo} <= modelHiLo(reset, control, a, b, sa, mHi, mLo);
      if (!reset) mValid <= 1'b1;
   end

   initial mValid = 1'b0;

   // Compare process: every negedge once the model is defined.
   always @(negedge clk) begin
      if (mValid) begin
         check("r", r, modelR(control, a, b, sa));
         check("zero", {31'h0, zero}, {31'h0, (modelR(control, a, b, sa) == 32'h0)});
         check("hi", hi, mHi);
         check("lo", lo, mLo);
         if (exp_q.size() > 0) check("r_literal", r, exp_q.pop_front());
      end
   end

   // Driver: apply one set of inputs just after a rising edge.
   task automatic drive(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] s, input logic rst);
      @(posedge clk);
      #1;
      control = c;
      a       = av;
      b       = bv;
      sa      = s;
      reset   = rst;
   endtask

   task automatic directR(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] s, input logic [31:0] expR);
      drive(c, av, bv, s, 1'b1);
      exp_q.push_back(expR);
   endtask

   task automatic expectHiLo(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
      @(negedge clk);
      check({name, "_hi"}, hi, expHi);
      check({name, "_lo"}, lo, expLo);
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Stimulus: directed literal cases, then randomized traffic.
   initial begin
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b0);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("reset", 32'h0, 32'h0);

      directR(4'd3, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0);
      @(negedge clk);
      check("zero_wrap", {31'h0, zero}, 32'h1);
      directR(4'd4, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE);
      directR(4'd5, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1);
      directR(4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0);
      directR(4'd9, 32'h0, 32'h80000000, 5'd4, 32'hF8000000);
      directR(4'd8, 32'h0, 32'h80000000, 5'd4, 32'h08000000);
      directR(4'd7, 32'h0, 32'h1, 5'd31, 32'h80000000);
      directR(4'd8, 32'h0, 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5);

      drive(4'd10, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

      drive(4'd11, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("multu", 32'h2, 32'hFFFFFFFA);

      drive(4'd12, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

      drive(4'd13, 32'd7, 32'd0, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);

      drive(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("div_ovf", 32'h0, 32'h80000000);

      drive(4'd14, 32'h1234, 32'h0, 5'd1, 1'b1);
      drive(4'd14, 32'h5678, 32'h0, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("mthilo", 32'h1234, 32'h5678);

      drive(4'd14, 32'h9999, 32'h0, 5'd1, 1'b0);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      expectHiLo("reset_prio", 32'h0, 32'h0);

      for (int i = 0; i < 800; i++) begin
         drive(4'($urandom_range(0, 15)), randOperand(), randOperand(),
               5'($urandom_range(0, 31)), ($urandom_range(0, 29) != 0));
      end

      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      drive(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
